// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and helpers for the data memory unit
package dmem_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } dmem_state_t;

    // The reserved size code falls into the word case, so it is checked as a word
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_HALF: is_misaligned = addr_lo[0];
            SZ_BYTE: is_misaligned = 1'b0;
            default: is_misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - big-endian lane extract for loads and write-merge for stores
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] next_word,
    output logic [3:0]  byte_en
);

    logic [15:0] half_v;
    logic [7:0]  byte_v;
    logic [1:0]  lane;

    // Offset 0 is the most significant byte, so the lane number runs opposite to the offset
    assign lane = 2'd3 - offset;

    always_comb begin
        load_data = word;
        next_word = wdata;
        byte_en   = 4'b1111;
        half_v    = offset[1] ? word[15:0] : word[31:16];
        byte_v    = word[{lane, 3'b000} +: 8];
        case (size)
            SZ_HALF: begin
                load_data = {{16{sign_ext & half_v[15]}}, half_v};
                next_word = word;
                if (offset[1]) begin
                    next_word[15:0] = wdata[15:0];
                    byte_en         = 4'b0011;
                end else begin
                    next_word[31:16] = wdata[15:0];
                    byte_en          = 4'b1100;
                end
            end
            SZ_BYTE: begin
                load_data = {{24{sign_ext & byte_v[7]}}, byte_v};
                next_word = word;
                next_word[{lane, 3'b000} +: 8] = wdata[7:0];
                byte_en = 4'b0000;
                byte_en[lane] = 1'b1;
            end
            default: begin
                load_data = word;
                next_word = wdata;
                byte_en   = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_unit.sv
// rtl/data_memory_unit.sv - single-cycle data memory with combinational load and self-clearing reset
module data_memory_unit
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS    = 64,
    parameter bit CLEAR_ON_RESET = 1
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  SizeSel,
    input  logic        SignExt,
    output logic [31:0] ReadData,
    output logic        Busy,
    output logic        AlignFault
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH_WORDS - 1);

    logic [31:0]   mem [DEPTH_WORDS];
    dmem_state_t   state;
    logic [AW-1:0] ptr;
    logic [AW-1:0] idx;
    logic          misaligned;
    logic [31:0]   load_data;
    logic [31:0]   next_word;
    logic [3:0]    byte_en;
    logic          unused_addr_bits;

    // Upper address bits only alias the same words
    assign idx              = Address[AW+1:2];
    assign unused_addr_bits = ^Address[31:AW+2];
    assign misaligned       = is_misaligned(SizeSel, Address[1:0]);
    assign Busy             = (state == ST_CLEAR);

    dmem_lane_align u_lane_align (
        .word      (mem[idx]),
        .offset    (Address[1:0]),
        .size      (SizeSel),
        .sign_ext  (SignExt),
        .wdata     (WriteData),
        .load_data (load_data),
        .next_word (next_word),
        .byte_en   (byte_en)
    );

    assign ReadData = (MemRead && !Busy && !misaligned && !Reset) ? load_data : 32'h0;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            ptr        <= '0;
            AlignFault <= 1'b0;
        end else if (state == ST_CLEAR) begin
            ptr <= ptr + 1'b1;
            if (ptr == LAST_PTR) begin
                state <= ST_READY;
            end
        end else if ((MemRead || MemWrite) && misaligned) begin
            AlignFault <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            if (state == ST_CLEAR) begin
                mem[ptr] <= 32'h0;
            end else if (MemWrite && !misaligned) begin
                for (int i = 0; i < 4; i++) begin
                    if (byte_en[i]) begin
                        mem[idx][i*8 +: 8] <= next_word[i*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_unit.sv
// tb/tb_data_memory_unit.sv - directed and randomized checks of data_memory_unit against a reference model
module tb_data_memory_unit;

    localparam int DEPTH = 64;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] WriteData = '0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [1:0]  SizeSel = 2'b00;
    logic        SignExt = 1'b0;
    logic [31:0] ReadData;
    logic        Busy;
    logic        AlignFault;

    int n_checks = 0;
    int n_pass = 0;
    logic [31:0] model [DEPTH];
    logic        model_fault;

    data_memory_unit #(.DEPTH_WORDS(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Address    (Address),
        .WriteData  (WriteData),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .SizeSel    (SizeSel),
        .SignExt    (SignExt),
        .ReadData   (ReadData),
        .Busy       (Busy),
        .AlignFault (AlignFault)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic int word_of(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    function automatic bit model_misaligned(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'd2) return 1'b0;
        if (sz == 2'd1) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                               input logic [1:0] sz, input logic sx);
        logic [31:0] v;
        int sh;
        if (sz == 2'd1) begin
            sh = (a % 4 >= 2) ? 0 : 16;
            v = (w >> sh) & 32'h0000ffff;
            if (sx && v >= 32'h8000) v = v + 32'hffff0000;
        end else if (sz == 2'd2) begin
            sh = (3 - int'(a % 4)) * 8;
            v = (w >> sh) & 32'h000000ff;
            if (sx && v >= 32'h80) v = v + 32'hffffff00;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input logic [31:0] a,
                                                input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] mask;
        int sh;
        if (sz == 2'd1) begin
            sh = (a % 4 >= 2) ? 0 : 16;
            mask = 32'h0000ffff << sh;
        end else if (sz == 2'd2) begin
            sh = (3 - int'(a % 4)) * 8;
            mask = 32'h000000ff << sh;
        end else begin
            sh = 0;
            mask = 32'hffffffff;
        end
        return (w & ~mask) | ((d << sh) & mask);
    endfunction

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [1:0] sz, input logic sx, input logic [31:0] d);
        MemRead = rd;
        MemWrite = wr;
        Address = a;
        SizeSel = sz;
        SignExt = sx;
        WriteData = d;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
    endtask

    task automatic count_clear(input string tag);
        int cnt;
        cnt = 0;
        while (Busy && cnt < 200) begin
            step();
            cnt++;
        end
        check(tag, 32'(cnt), 32'd64);
    endtask

    initial begin
        logic [31:0] a, d, exp_rd;
        logic [1:0]  sz;
        logic        rd, wr, sx;

        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        model_fault = 1'b0;

        // Reset state and clear timing
        Reset = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
        step();
        check("reset_busy", 32'(Busy), 32'd1);
        check("reset_rdata", ReadData, 32'h0);
        check("reset_fault", 32'(AlignFault), 32'd0);
        Reset = 1'b0;
        idle();
        count_clear("clear_cycles");
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, 32'(i * 4), 2'd0, 1'b0, 32'h0);
            check("cleared_word", ReadData, 32'h0);
        end

        // Word store and sub-word loads with extension
        drive(1'b0, 1'b1, 32'h20, 2'd0, 1'b0, 32'hfeedbeef);
        step();
        model[8] = 32'hfeedbeef;
        drive(1'b1, 1'b0, 32'h20, 2'd0, 1'b0, 32'h0);
        check("word_load", ReadData, 32'hfeedbeef);
        drive(1'b1, 1'b0, 32'h23, 2'd2, 1'b1, 32'h0);
        check("byte_sx", ReadData, 32'hffffffef);
        drive(1'b1, 1'b0, 32'h23, 2'd2, 1'b0, 32'h0);
        check("byte_zx", ReadData, 32'h000000ef);
        drive(1'b1, 1'b0, 32'h22, 2'd1, 1'b1, 32'h0);
        check("half_sx", ReadData, 32'hffffbeef);
        drive(1'b1, 1'b0, 32'h20, 2'd1, 1'b0, 32'h0);
        check("half_hi_zx", ReadData, 32'h0000feed);
        drive(1'b0, 1'b1, 32'h22, 2'd2, 1'b0, 32'h00000048);
        step();
        model[8] = 32'hfeed48ef;
        drive(1'b1, 1'b0, 32'h20, 2'd0, 1'b0, 32'h0);
        check("byte_store", ReadData, 32'hfeed48ef);

        // Misaligned word store
        check("fault_before", 32'(AlignFault), 32'd0);
        drive(1'b1, 1'b1, 32'h21, 2'd0, 1'b0, 32'h12345678);
        check("misalign_rdata", ReadData, 32'h0);
        step();
        model_fault = 1'b1;
        idle();
        check("fault_set", 32'(AlignFault), 32'd1);
        drive(1'b1, 1'b0, 32'h20, 2'd0, 1'b0, 32'h0);
        check("misalign_nowrite", ReadData, 32'hfeed48ef);
        step();
        step();
        check("fault_sticky", 32'(AlignFault), 32'd1);

        // Read and write of the same word in one cycle
        drive(1'b1, 1'b1, 32'h40, 2'd0, 1'b0, 32'h1);
        check("rw_same_old", ReadData, 32'h0);
        step();
        model[16] = 32'h1;
        drive(1'b1, 1'b0, 32'h40, 2'd0, 1'b0, 32'h0);
        check("rw_same_new", ReadData, 32'h1);

        // Address wrap-around
        drive(1'b0, 1'b1, 32'h100, 2'd0, 1'b0, 32'ha5a5a5a5);
        step();
        model[0] = 32'ha5a5a5a5;
        drive(1'b1, 1'b0, 32'h000, 2'd0, 1'b0, 32'h0);
        check("wrap_load", ReadData, 32'ha5a5a5a5);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            a  = $urandom_range(0, 1023);
            sz = 2'($urandom_range(0, 3));
            sx = 1'($urandom_range(0, 1));
            d  = $urandom;
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 2) == 0);
            drive(rd, wr, a, sz, sx, d);
            if (rd && !model_misaligned(a, sz))
                exp_rd = model_load(model[word_of(a)], a, sz, sx);
            else
                exp_rd = 32'h0;
            check("rand_rdata", ReadData, exp_rd);
            step();
            if (wr && !model_misaligned(a, sz))
                model[word_of(a)] = model_store(model[word_of(a)], a, sz, d);
            if ((rd || wr) && model_misaligned(a, sz))
                model_fault = 1'b1;
            idle();
            check("rand_fault", 32'(AlignFault), 32'(model_fault));
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, 32'(i * 4), 2'd0, 1'b0, 32'h0);
            check("rand_final", ReadData, model[i]);
        end

        // Reset during a clear restarts it; reset wins over a pending store
        Reset = 1'b1;
        drive(1'b0, 1'b1, 32'h44, 2'd0, 1'b0, 32'hdeadbeef);
        step();
        check("rst_fault_clr", 32'(AlignFault), 32'd0);
        Reset = 1'b0;
        idle();
        for (int i = 0; i < 30; i++) step();
        check("midclear_busy", 32'(Busy), 32'd1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        idle();
        count_clear("restart_cycles");
        drive(1'b1, 1'b0, 32'h44, 2'd0, 1'b0, 32'h0);
        check("rst_store_blocked", ReadData, 32'h0);
        drive(1'b1, 1'b0, 32'h20, 2'd0, 1'b0, 32'h0);
        check("recleared", ReadData, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
